// File: rtl/parking_job_scheduler.sv
// Front-end sequencer for the parking-lot elevator: queues in/out requests,
// tracks leakage as a priority job and issues one job at a time on todo_*.
module parking_job_scheduler #(
  parameter int DEPTH   = 4,
  parameter int PLATE_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [PLATE_W-1:0]       license_plate,
  input  logic                     in_mode,
  input  logic                     out_mode,
  input  logic                     leakage,
  input  logic [2:0]               leakage_floor,
  input  logic                     job_done,
  output logic                     todo_exists,
  output logic                     todo_in,
  output logic                     todo_out,
  output logic                     todo_leak_move,
  output logic [PLATE_W-1:0]       todo_license_plate,
  output logic [2:0]               todo_leak_floor,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic                     queue_full,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state;
  logic [PLATE_W:0]    mem [DEPTH];
  logic [PLATE_W:0]    head;
  logic [AW-1:0]       rd_ptr, wr_ptr;
  logic [CW-1:0]       count;
  logic                leak_prev, leak_pending;
  logic [2:0]          leak_floor;
  logic                push, pop, issue_leak, leak_rise;

  // Issue decisions come from registered state only, so a push can use the
  // slot freed by the pop on the same edge.
  always_comb begin
    issue_leak = (state == IDLE) && leak_pending;
    pop        = (state == IDLE) && !leak_pending && (count != '0);
    push       = (in_mode ^ out_mode) && (license_plate != '0) &&
                 ((count != CW'(DEPTH)) || pop);
    leak_rise  = leakage && !leak_prev && (leakage_floor != 3'd0);
  end

  assign head        = mem[rd_ptr];
  assign queue_count = count;
  assign queue_full  = (count == CW'(DEPTH));

  // NOTE: the storage array carries no reset; an entry is only read after it
  // has been written, and leaving it out keeps it mappable to plain RAM/flops.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {out_mode, license_plate};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      drop   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      drop  <= (in_mode | out_mode) & ~push;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      leak_prev          <= 1'b0;
      leak_pending       <= 1'b0;
      leak_floor         <= '0;
      todo_exists        <= 1'b0;
      todo_in            <= 1'b0;
      todo_out           <= 1'b0;
      todo_leak_move     <= 1'b0;
      todo_license_plate <= '0;
      todo_leak_floor    <= '0;
    end else begin
      leak_prev <= leakage;
      // A fresh rising edge re-arms the leak even on the edge that issues the old one.
      if (leak_rise) begin
        leak_pending <= 1'b1;
        leak_floor   <= leakage_floor;
      end else if (issue_leak) begin
        leak_pending <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (issue_leak) begin
            state              <= BUSY;
            todo_exists        <= 1'b1;
            todo_leak_move     <= 1'b1;
            todo_in            <= 1'b0;
            todo_out           <= 1'b0;
            todo_license_plate <= '0;
            todo_leak_floor    <= leak_floor;
          end else if (pop) begin
            state              <= BUSY;
            todo_exists        <= 1'b1;
            todo_leak_move     <= 1'b0;
            todo_in            <= ~head[PLATE_W];
            todo_out           <= head[PLATE_W];
            todo_license_plate <= head[PLATE_W-1:0];
            todo_leak_floor    <= '0;
          end
        end
        BUSY: begin
          if (job_done) begin
            state              <= IDLE;
            todo_exists        <= 1'b0;
            todo_in            <= 1'b0;
            todo_out           <= 1'b0;
            todo_leak_move     <= 1'b0;
            todo_license_plate <= '0;
            todo_leak_floor    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parking_job_scheduler.sv
// Directed and randomized bench for parking_job_scheduler against a
// queue-based reference model of the scheduling rules.
module tb_parking_job_scheduler;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] license_plate;
  logic        in_mode, out_mode, leakage, job_done;
  logic [2:0]  leakage_floor;
  logic        todo_exists, todo_in, todo_out, todo_leak_move;
  logic [15:0] todo_license_plate;
  logic [2:0]  todo_leak_floor;
  logic [2:0]  queue_count;
  logic        queue_full, drop;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  parking_job_scheduler #(.DEPTH(DEPTH), .PLATE_W(16)) dut (
    .clock(clock), .reset(reset), .license_plate(license_plate),
    .in_mode(in_mode), .out_mode(out_mode), .leakage(leakage),
    .leakage_floor(leakage_floor), .job_done(job_done),
    .todo_exists(todo_exists), .todo_in(todo_in), .todo_out(todo_out),
    .todo_leak_move(todo_leak_move), .todo_license_plate(todo_license_plate),
    .todo_leak_floor(todo_leak_floor), .queue_count(queue_count),
    .queue_full(queue_full), .drop(drop)
  );

  always #5 clock = ~clock;

  // Reference model: a request queue plus the currently issued job.
  typedef struct packed {logic is_out; logic [15:0] plate;} req_t;
  req_t        q[$];
  bit          m_busy, m_in, m_out, m_leak, m_pend, m_prev, m_drop;
  logic [15:0] m_plate;
  logic [2:0]  m_lfloor, m_pfloor;
  logic        leak_lvl;
  logic [2:0]  leak_fl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    {m_busy, m_in, m_out, m_leak, m_pend, m_prev, m_drop} = '0;
    m_plate = '0; m_lfloor = '0; m_pfloor = '0;
  endtask

  task automatic model_step();
    req_t h;
    bit do_leak, do_pop, accept, rise;
    do_leak = !m_busy && m_pend;
    do_pop  = !m_busy && !m_pend && q.size() > 0;
    accept  = (in_mode ^ out_mode) && license_plate != 16'd0 && (q.size() < DEPTH || do_pop);
    m_drop  = (in_mode || out_mode) && !accept;
    rise    = leakage && !m_prev && leakage_floor != 3'd0;
    if (m_busy) begin
      if (job_done) begin
        {m_busy, m_in, m_out, m_leak} = '0;
        m_plate = '0; m_lfloor = '0;
      end
    end else if (do_leak) begin
      m_busy = 1; m_leak = 1; m_in = 0; m_out = 0; m_plate = '0; m_lfloor = m_pfloor;
    end else if (do_pop) begin
      h = q.pop_front();
      m_busy = 1; m_leak = 0; m_in = !h.is_out; m_out = h.is_out;
      m_plate = h.plate; m_lfloor = '0;
    end
    if (accept) q.push_back(req_t'({out_mode, license_plate}));
    if (rise) begin
      m_pend = 1; m_pfloor = leakage_floor;
    end else if (do_leak) begin
      m_pend = 0;
    end
    m_prev = leakage;
  endtask

  task automatic compare_model();
    logic [31:0] act, exp;
    act = {4'd0, todo_exists, todo_in, todo_out, todo_leak_move, todo_license_plate,
           todo_leak_floor, queue_count, queue_full, drop};
    exp = {4'd0, m_busy, m_in, m_out, m_leak, m_plate, m_lfloor,
           3'(q.size()), q.size() == DEPTH, m_drop};
    check($sformatf("outputs_cyc%0d", cyc), act, exp);
  endtask

  task automatic cycle(input logic i, input logic o, input logic [15:0] p, input logic jd);
    @(negedge clock);
    in_mode = i; out_mode = o; license_plate = p; job_done = jd;
    leakage = leak_lvl; leakage_floor = leak_fl;
    @(posedge clock);
    model_step();
    cyc++;
    #1 compare_model();
  endtask

  task automatic nop(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 16'd0, 0);
  endtask

  initial begin
    logic [15:0] plates [4];
    plates[0] = 16'h8754; plates[1] = 16'h5755; plates[2] = 16'h3851; plates[3] = 16'h9522;
    reset = 1'b0; in_mode = 0; out_mode = 0; license_plate = '0; leakage = 0;
    leakage_floor = '0; job_done = 0; leak_lvl = 0; leak_fl = '0;
    model_reset();
    #12 compare_model();
    check("reset_exists", todo_exists, 0);
    @(negedge clock) reset = 1'b1;

    // Single in request: issued two edges after the pulse, then held stable.
    cycle(1, 0, 16'h9423, 0);
    nop(1);
    check("first_exists", todo_exists, 1);
    check("first_in", todo_in, 1);
    check("first_plate", todo_license_plate, 16'h9423);
    check("first_count", queue_count, 0);
    nop(5);
    check("held_plate", todo_license_plate, 16'h9423);
    cycle(0, 0, 16'd0, 1);
    check("retired", todo_exists, 0);

    // Fill the queue while busy; the fifth request is dropped.
    cycle(1, 0, 16'h1111, 0);
    nop(1);
    cycle(1, 0, 16'h8754, 0);
    cycle(1, 0, 16'h5755, 0);
    cycle(0, 1, 16'h3851, 0);
    cycle(1, 0, 16'h9522, 0);
    check("full_flag", queue_full, 1);
    check("full_count", queue_count, 4);
    cycle(1, 0, 16'h9532, 0);
    check("full_drop", drop, 1);
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 16'd0, 1);
      check("gap_low", todo_exists, 0);
      nop(1);
      check($sformatf("order_plate%0d", k), todo_license_plate, plates[k]);
      check($sformatf("order_out%0d", k), todo_out, (k == 2));
    end
    cycle(0, 0, 16'd0, 1);

    // Leak arriving while busy jumps ahead of queued requests.
    cycle(1, 0, 16'h2222, 0);
    nop(1);
    cycle(1, 0, 16'h3333, 0);
    cycle(0, 1, 16'h4444, 0);
    leak_lvl = 1; leak_fl = 3'd1;
    nop(2);
    check("leak_waits", todo_license_plate, 16'h2222);
    cycle(0, 0, 16'd0, 1);
    nop(1);
    check("leak_move", todo_leak_move, 1);
    check("leak_floor", todo_leak_floor, 1);
    check("leak_plate", todo_license_plate, 0);
    leak_lvl = 0;
    cycle(0, 0, 16'd0, 1);
    nop(1);
    check("after_leak_plate", todo_license_plate, 16'h3333);
    cycle(0, 0, 16'd0, 1);
    nop(1);
    check("after_leak_out", todo_out, 1);
    cycle(0, 0, 16'd0, 1);

    // Rejections: both modes, zero plate, leak on floor 0.
    cycle(1, 1, 16'h5555, 0);
    check("both_drop", drop, 1);
    check("both_count", queue_count, 0);
    cycle(1, 0, 16'd0, 0);
    check("zero_drop", drop, 1);
    leak_lvl = 1; leak_fl = 3'd0;
    nop(3);
    check("floor0_ignored", todo_exists, 0);
    leak_lvl = 0;
    nop(1);

    // Full queue: issue pop and push on the same edge.
    cycle(1, 0, 16'h6001, 0);
    nop(1);
    for (int k = 2; k <= 5; k++) cycle(1, 0, 16'h6000 + 16'(k), 0);
    cycle(0, 0, 16'd0, 1);
    cycle(1, 0, 16'h6006, 0);
    check("pp_drop", drop, 0);
    check("pp_count", queue_count, 4);
    check("pp_plate", todo_license_plate, 16'h6002);

    // Asynchronous reset while busy with three queued.
    cycle(0, 0, 16'd0, 1);
    nop(1);
    check("pre_reset_count", queue_count, 3);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("async_exists", todo_exists, 0);
    check("async_count", queue_count, 0);
    compare_model();
    @(posedge clock);
    #1 compare_model();
    @(negedge clock) reset = 1'b1;
    cycle(1, 0, 16'h7777, 0);
    nop(1);
    check("post_reset_plate", todo_license_plate, 16'h7777);
    cycle(0, 0, 16'd0, 1);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      int r;
      logic i, o, jd;
      logic [15:0] p;
      r  = int'($urandom_range(0, 9));
      i  = (r == 0) || (r == 2);
      o  = (r == 1) || (r == 2 && $urandom_range(0, 3) == 0);
      p  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      jd = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) == 0) leak_lvl = ~leak_lvl;
      leak_fl = 3'($urandom_range(0, 7));
      cycle(i, o, p, jd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parking_job_scheduler.md
Name: parking_job_scheduler

Overview:
- Front-end sequencer for the parking-lot elevator datapath.
- Captures single-cycle in/out requests into a FIFO and tracks water-leakage events as a separate priority job.
- Issues exactly one job at a time to the elevator controller on the todo_* interface, and holds it until the controller returns job_done.
- Sits between the top-level user inputs and the elevator/slot datapath inside parking_lot_top.

Parameters:
DEPTH, 4, request FIFO entries (power of 2, ≥2)
PLATE_W, 16, license plate width (4 BCD digits)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
license_plate  input  PLATE_W  plate for in/out request, valid with in_mode/out_mode
in_mode  input  1  1-cycle pulse: car entering
out_mode  input  1  1-cycle pulse: car leaving
leakage  input  1  level: leakage present
leakage_floor  input  3  leaking floor, valid while leakage=1
job_done  input  1  1-cycle pulse from elevator controller: current job finished
todo_exists  output  1  a job is issued and outstanding
todo_in  output  1  issued job is park-in
todo_out  output  1  issued job is retrieve-out
todo_leak_move  output  1  issued job is evacuate leaking floor
todo_license_plate  output  PLATE_W  plate of issued in/out job; 0 for leak job
todo_leak_floor  output  3  floor of issued leak job; 0 otherwise
queue_count  output  $clog2(DEPTH)+1  FIFO occupancy
queue_full  output  1  queue_count==DEPTH
drop  output  1  1-cycle pulse: request rejected

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty, leak_pending=0, state=IDLE, all outputs 0. Any in-flight job is abandoned and no job_done is expected.
- FIFO entry = {is_out, plate}. Push is evaluated on the rising clock edge.
- Push conditions:
  - in_mode^out_mode=1, plate≠0, and (count<DEPTH or a pop occurs on the same edge).
  - in_mode=out_mode=1 → drop=1, nothing queued.
  - plate==0 → drop=1.
  - full without a simultaneous pop → drop=1, count unchanged.
- Leak tracking:
  - Rising edge of leakage (registered previous value) with leakage_floor in 1..7 → leak_pending=1, leak_floor latched.
  - While leak_pending=1 and not yet issued, a new rising edge overwrites leak_floor.
  - leakage_floor=0 → ignored, no drop.
  - A leak request and an in/out request in the same cycle are both accepted.
- State machine, IDLE / BUSY:
  - IDLE:
    - If leak_pending, issue the leak job (clear leak_pending) → BUSY.
    - Else if FIFO non-empty, pop the head and issue it → BUSY.
    - Leak always wins over the FIFO.
  - BUSY:
    - todo_exists=1. Exactly one of todo_in/todo_out/todo_leak_move is 1.
    - todo_* are registered and stable until the job retires.
    - job_done=1 → all todo_* cleared on that edge → IDLE.
    - Non-preemptive: a leak arriving during BUSY waits.
  - job_done in IDLE is ignored.
- Latency:
  - A request pushed at edge k into an empty, idle scheduler shows todo_exists=1 after edge k+1.
  - After job_done at edge j, the next job is issued at edge j+1 (todo_exists low for exactly one cycle).
- The pop at issue and a push on the same edge are both honored; count is net unchanged.
- FIFO pointers wrap modulo DEPTH. count never exceeds DEPTH or underflows.
- No duplicate-plate filtering here; that is the datapath's responsibility.

Test Plan:
- Reset, then in_mode pulse with plate 9423 → 2 cycles later todo_exists=1, todo_in=1, todo_license_plate=9423, queue_count=0. Hold job_done=0 for 5 cycles → outputs stable. Pulse job_done → todo_exists=0 next cycle.
- Keep a job BUSY. Push 8754(in), 5755(in), 3851(out), 9522(in), 9532(in) → first four accepted, queue_full=1, fifth gives drop=1. Retire jobs → issued in FIFO order 8754, 5755, 3851(todo_out), 9522.
- While BUSY with 2 queued requests, raise leakage with floor 1 → after job_done the next job is todo_leak_move=1, todo_leak_floor=1, todo_license_plate=0. Queued requests follow afterward.
- Same cycle: in_mode=out_mode=1 → drop=1, count unchanged. In a separate cycle: in_mode=1 with plate 0 → drop=1. In a separate cycle: leakage rising with floor 0 → no job issued.
- Full FIFO with job_done and an in_mode push on the same edge as the next issue → push accepted, count stays DEPTH, no drop.
- Assert reset=0 mid-BUSY with 3 queued → todo_* and queue_count go to 0 immediately, without waiting for a clock edge. After release, a new request issues normally.
